load_data_formatter: RTL
========================

# load_data_formatter

Parametrised load-data alignment and extension unit in the memory-writeback path, between the data-memory read port and the register-file write mux. It takes one aligned memory word per beat and selects the addressed byte, halfword, word or two-beat doubleword. It then zero- or sign-extends the result to a 2×DATA_W output. Results are registered behind a valid/ready handshake, and misaligned accesses are flagged.

## Interface
- DATA_W, 32, memory beat width in bits; power of two, ≥16.
- OFF_W, log2(DATA_W/8), byte-offset width; derived, not overridden.
- clk  input  1  rising-edge clock; sole clock.
- reset  input  1  synchronous, active-high reset.
- sext_en  input  1  global sign-extension enable; 0 forces zero-extension for all sizes.
- in_valid  input  1  input beat valid.
- in_ready  output  1  unit accepts beat this cycle.
- in_data  input  DATA_W  memory word.
- in_offset  input  OFF_W  byte address within word.
- in_size  input  2  00 byte, 01 half, 10 word, 11 doubleword (two beats).
- in_signed  input  1  signed load request.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  2×DATA_W  extended result.
- out_err  output  1  misaligned access; qualifies out_valid.

## Operation
- A beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready, in every state.
- Extension: sext = sext_en && in_signed. The selected field is sign-extended from its MSB to 2×DATA_W when sext=1; otherwise it is zero-extended.
- Byte: the field is in_data[8*off+7 : 8*off]. Any offset is legal.
- Half: the field is in_data[8*off+15 : 8*off]. off[0]≠0 is misaligned.
- Word: the field is all of in_data. off≠0 is misaligned.
- Double:
  - The first beat is the low DATA_W bits; off≠0 on it is misaligned.
  - The second beat supplies the high DATA_W bits. Its size, offset and signed fields are ignored.
  - No extension is applied; the result is {beat2, beat1}.
- Misaligned: the result completes on that beat with out_err=1 and out_data=0. A misaligned double does not wait for a second beat.
- State machine:
  - IDLE: single-beat access → result register loaded, stay IDLE. Aligned double first beat → low register loaded, go HI.
  - HI: next accepted beat → result {in_data, lo} loaded, go IDLE.
- The result register loads on accept of a completing beat. out_valid clears on out_ready when no new result loads in the same cycle.
- A simultaneous output handshake and completing input accept replace the result, and out_valid stays 1. Throughput is one result per cycle.
- Accepting a double first beat while the output is held is allowed (in_ready rule above). It does not disturb out_data.
- Reset: state IDLE, lo register 0, out_valid 0, out_data 0, out_err 0. A partial double held in HI is discarded.

## Timing
- Latency is 1 cycle: a completing beat accepted at edge N gives out_valid=1 after edge N.
- A doubleword spans at least 2 accepts. There is no minimum gap between its beats; gaps with in_valid=0 in HI are held indefinitely.
- out_data/out_err are stable while out_valid && !out_ready.
- in_ready is combinational from out_valid and out_ready only, with no in_valid→in_ready path.
- sext_en is sampled on the accepting edge.
- Reset asserted in any cycle wins over every accept or handshake that edge. in_ready is 1 on the first cycle after reset.

## Test plan
- Byte, signed, sext_en=1, in_data=0x12805634, off=2 → out_data=0xFFFFFFFF_FFFFFF80, err=0. Repeat with sext_en=0 → 0x00000000_00000080.
- Half: unsigned, off=0, in_data=0x00008001 → 0x00000000_00008001. Signed, off=2, in_data=0x12805634 → 0x00000000_00001280.
- Word, signed, in_data=0x80000000 → 0xFFFFFFFF_80000000. Double: beats 0x89ABCDEF then 0x01234567 → 0x01234567_89ABCDEF, exactly one out_valid.
- Misaligned: half off=1 → err=1, data 0. Double first beat off=2 → err=1 immediately, and the next beat is treated as a new request.
- Backpressure:
  - Hold out_ready=0 with 3 byte requests offered → first result held stable, in_ready=0, second request stalled.
  - Release out_ready → results delivered back-to-back one per cycle, in order.
- Reset in HI after a double low beat 0xDEADBEEF → out_valid=0, state IDLE. A following word 0x00000005 → 0x00000000_00000005.

Source files
------------

// File: rtl/load_data_formatter_if.sv
// Load-data formatter bus: memory-beat input side and extended-result output side.
interface load_data_formatter_if #(
   parameter int DATA_W = 32
);
   localparam int OFF_W = $clog2(DATA_W / 8);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_W-1:0]     in_data;
   logic [OFF_W-1:0]      in_offset;
   logic [1:0]            in_size;
   logic                  in_signed;
   logic                  out_valid;
   logic                  out_ready;
   logic [2*DATA_W-1:0]   out_data;
   logic                  out_err;

   modport master (
      output in_valid, in_data, in_offset, in_size, in_signed, out_ready,
      input  in_ready, out_valid, out_data, out_err
   );

   modport slave (
      input  in_valid, in_data, in_offset, in_size, in_signed, out_ready,
      output in_ready, out_valid, out_data, out_err
   );
endinterface

// File: rtl/load_data_formatter.sv
// Load-data alignment and extension unit for the writeback path.
// Selects byte/half/word from one memory beat, or joins two beats into a
// doubleword, then zero- or sign-extends to 2*DATA_W behind a registered
// valid/ready output. Misaligned accesses complete at once with out_err=1.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no partial access; next accepted beat starts a new request
// S_HI   | low half of a doubleword held in lo_q; next beat is the high half
module load_data_formatter #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sext_en,
   load_data_formatter_if.slave  bus
);

   localparam int OFF_W = $clog2(DATA_W / 8);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_DBL  = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HI   = 1'b1
   } state_t;

   state_t                state_q;
   logic [DATA_W-1:0]     lo_q;
   logic                  out_valid_q;
   logic [2*DATA_W-1:0]   out_data_q;
   logic                  out_err_q;

   logic                  in_ready;
   logic                  accept;
   logic                  sext;
   logic [DATA_W-1:0]     shifted;
   logic [7:0]            byte_f;
   logic [15:0]           half_f;
   logic                  dbl_start;
   logic [2*DATA_W-1:0]   fmt_data;
   logic                  fmt_err;

   // Ready depends only on the output register, never on in_valid.
   assign in_ready = !out_valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign sext     = sext_en && bus.in_signed;

   // Bring the addressed byte lane down to bit 0.
   assign shifted  = bus.in_data >> {bus.in_offset, 3'b000};
   assign byte_f   = shifted[7:0];
   assign half_f   = shifted[15:0];

   // Only an aligned doubleword seen in IDLE parks its low beat.
   assign dbl_start = (state_q == S_IDLE) && (bus.in_size == SZ_DBL) &&
                      (bus.in_offset == '0);

   // Single-beat field selection, extension and alignment check.
   always_comb begin
      fmt_data = '0;
      fmt_err  = 1'b0;
      case (bus.in_size)
         SZ_BYTE: begin
            fmt_data = {{(2*DATA_W-8){sext & byte_f[7]}}, byte_f};
         end
         SZ_HALF: begin
            if (bus.in_offset[0]) begin
               fmt_err = 1'b1;
            end else begin
               fmt_data = {{(2*DATA_W-16){sext & half_f[15]}}, half_f};
            end
         end
         SZ_WORD: begin
            if (bus.in_offset != '0) begin
               fmt_err = 1'b1;
            end else begin
               fmt_data = {{DATA_W{sext & bus.in_data[DATA_W-1]}}, bus.in_data};
            end
         end
         default: begin
            // Doubleword reaching here is a misaligned first beat; an aligned
            // one is captured into lo_q instead of completing.
            fmt_err = (bus.in_offset != '0);
         end
      endcase
   end

   // Sequencing FSM with the registered result and the parked low beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         lo_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_err_q   <= 1'b0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
         end
         if (accept) begin
            if (state_q == S_HI) begin
               out_data_q  <= {bus.in_data, lo_q};
               out_err_q   <= 1'b0;
               out_valid_q <= 1'b1;
               state_q     <= S_IDLE;
            end else if (dbl_start) begin
               // Held output is untouched while the low beat is parked.
               lo_q    <= bus.in_data;
               state_q <= S_HI;
            end else begin
               out_data_q  <= fmt_data;
               out_err_q   <= fmt_err;
               out_valid_q <= 1'b1;
            end
         end
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_err   = out_err_q;

endmodule
